// File: rtl/spi_word_slave_rx_if.sv
// SPI pin and received-word bundle for spi_word_slave_rx.
// slave modport faces the deserializer; master modport faces the SPI master / word consumer.
interface spi_word_slave_rx_if #(
  parameter int WORD_BITS = 24
);
  logic                 i_SPI_Clk;
  logic                 i_SPI_MOSI;
  logic                 i_SPI_CS_n;
  logic                 o_SPI_MISO;
  logic [WORD_BITS-1:0] o_RX_Word;
  logic                 o_RX_DV;
  logic                 o_Frame_Err;
  logic [7:0]           o_Word_Count;

  modport slave (
    input  i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n,
    output o_SPI_MISO, o_RX_Word, o_RX_DV, o_Frame_Err, o_Word_Count
  );

  modport master (
    output i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n,
    input  o_SPI_MISO, o_RX_Word, o_RX_DV, o_Frame_Err, o_Word_Count
  );
endinterface

// File: rtl/spi_word_slave_rx.sv
// Oversampled SPI peripheral deserializer: WORD_BITS-bit MSB-first words out with a 1-cycle valid.
// Optional MISO echo of the previously completed word when SPI_SLAVE_ECHO_EN is defined.
module spi_word_slave_rx #(
  parameter int SPI_MODE    = 3,
  parameter int WORD_BITS   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  spi_word_slave_rx_if.slave    spi
);
  localparam logic CPOL = (SPI_MODE >= 2);
  localparam logic CPHA = ((SPI_MODE % 2) == 1);
  localparam int   CW   = $clog2(WORD_BITS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [SYNC_STAGES:0]   warm_q, warm_d;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0]   shift_q, shift_d;
  logic                   done_q, done_d;
  logic                   err_pend_q, err_pend_d;
  logic                   rx_dv_q, rx_dv_d;
  logic                   frame_err_q, frame_err_d;
  logic [WORD_BITS-1:0]   rx_word_q, rx_word_d;
  logic [7:0]             word_cnt_q, word_cnt_d;

  logic sck_s, mosi_s, cs_s;
  logic sample_edge, cs_fall, cs_rise;
  logic [CW-1:0] cnt_next;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi.i_SPI_Clk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.i_SPI_MOSI};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi.i_SPI_CS_n};
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
    // Until the chain has flushed its reset value, a synced CS_n=1 is not real
    // and must not arm the FSM, or a frame already in progress would be joined.
    warm_d      = {warm_q[SYNC_STAGES-1:0], 1'b1};

    sample_edge = (CPOL == CPHA) ? (~sck_prev_q & sck_s) : (sck_prev_q & ~sck_s);
    cs_fall     = cs_prev_q & ~cs_s;
    cs_rise     = ~cs_prev_q & cs_s;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    err_pend_d = 1'b0;
    cnt_next   = bit_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (warm_q[SYNC_STAGES] && cs_s) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (cs_fall) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        // Sample is applied before a same-cycle CS rise, so a completing bit is not an error.
        if (sample_edge) begin
          shift_d = {shift_q[WORD_BITS-2:0], mosi_s};
          if (bit_cnt_q == CW'(WORD_BITS - 1)) begin
            cnt_next = '0;
            done_d   = 1'b1;
          end else begin
            cnt_next = bit_cnt_q + CW'(1);
          end
        end
        bit_cnt_d = cnt_next;
        if (cs_rise) begin
          state_d    = S_ARMED;
          err_pend_d = (cnt_next != '0);
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_dv_d     = done_q;
    frame_err_d = err_pend_q;
    rx_word_d   = done_q ? shift_q : rx_word_q;
    word_cnt_d  = done_q ? (word_cnt_q + 8'd1) : word_cnt_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sck_sync_q  <= {SYNC_STAGES{CPOL}};
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sck_prev_q  <= CPOL;
      cs_prev_q   <= 1'b1;
      warm_q      <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      err_pend_q  <= 1'b0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      rx_word_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      warm_q      <= warm_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      err_pend_q  <= err_pend_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
      rx_word_q   <= rx_word_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

`ifdef SPI_SLAVE_ECHO_EN
  logic [WORD_BITS-1:0] tx_q, tx_d;
  logic                 miso_q, miso_d;
  logic                 drive_edge;

  // CPHA=0 presents the MSB at CS fall and pre-shifts; CPHA=1 presents it on the first drive edge.
  always_comb begin
    drive_edge = (sck_prev_q ^ sck_s) & ~sample_edge;
    tx_d       = tx_q;
    miso_d     = miso_q;
    if (state_q == S_ARMED && cs_fall) begin
      tx_d   = CPHA ? rx_word_q : {rx_word_q[WORD_BITS-2:0], 1'b0};
      miso_d = CPHA ? 1'b0 : rx_word_q[WORD_BITS-1];
    end else if (state_q == S_SHIFT) begin
      if (done_d) begin
        tx_d = shift_d;
      end else if (drive_edge) begin
        miso_d = tx_q[WORD_BITS-1];
        tx_d   = {tx_q[WORD_BITS-2:0], 1'b0};
      end
    end
    if (state_d != S_SHIFT) miso_d = 1'b0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tx_q   <= '0;
      miso_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      miso_q <= miso_d;
    end
  end

  assign spi.o_SPI_MISO = miso_q;
`else
  assign spi.o_SPI_MISO = 1'b0;
`endif

  assign spi.o_RX_Word    = rx_word_q;
  assign spi.o_RX_DV      = rx_dv_q;
  assign spi.o_Frame_Err  = frame_err_q;
  assign spi.o_Word_Count = word_cnt_q;
endmodule

// File: tb/tb_spi_word_slave_rx.sv
// Directed bench for spi_word_slave_rx: mode-3 instance for most checks, mode-0 instance for capture.
module tb_spi_word_slave_rx;
  localparam int WB = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic sck_a = 1'b1, mosi_a = 1'b0, cs_a = 1'b1;
  logic sck_b = 1'b0, mosi_b = 1'b0, cs_b = 1'b1;

  spi_word_slave_rx_if #(.WORD_BITS(WB)) ifa ();
  spi_word_slave_rx_if #(.WORD_BITS(WB)) ifb ();

  assign ifa.i_SPI_Clk  = sck_a;
  assign ifa.i_SPI_MOSI = mosi_a;
  assign ifa.i_SPI_CS_n = cs_a;
  assign ifb.i_SPI_Clk  = sck_b;
  assign ifb.i_SPI_MOSI = mosi_b;
  assign ifb.i_SPI_CS_n = cs_b;

  spi_word_slave_rx #(.SPI_MODE(3), .WORD_BITS(WB), .SYNC_STAGES(2)) dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .spi(ifa)
  );
  spi_word_slave_rx #(.SPI_MODE(0), .WORD_BITS(WB), .SYNC_STAGES(2)) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .spi(ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [WB-1:0] qa[$];
  logic [WB-1:0] qb[$];
  int erra = 0, errb = 0, both_hi = 0, miso_hi = 0;

  always @(negedge clk) begin
    if (ifa.o_RX_DV) qa.push_back(ifa.o_RX_Word);
    if (ifb.o_RX_DV) qb.push_back(ifb.o_RX_Word);
    if (ifa.o_Frame_Err) erra++;
    if (ifb.o_Frame_Err) errb++;
    if ((ifa.o_RX_DV && ifa.o_Frame_Err) || (ifb.o_RX_DV && ifb.o_Frame_Err)) both_hi++;
`ifndef SPI_SLAVE_ECHO_EN
    if (ifa.o_SPI_MISO || ifb.o_SPI_MISO) miso_hi++;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  // Mode 3 master: drive on falling SCK, sample on rising SCK.
  task automatic a_bit(input logic b, output logic ms);
    sck_a  = 1'b0;
    mosi_a = b;
    half();
    ms    = ifa.o_SPI_MISO;
    sck_a = 1'b1;
    half();
  endtask

  task automatic a_word(input logic [WB-1:0] w, input int nbits, output logic [WB-1:0] echo);
    logic m;
    echo = '0;
    for (int i = 0; i < nbits; i++) begin
      a_bit(w[WB-1-i], m);
      echo = {echo[WB-2:0], m};
    end
  endtask

  task automatic a_cs_low();
    cs_a = 1'b0;
    half();
  endtask

  task automatic a_cs_high();
    half();
    cs_a = 1'b1;
    half();
    half();
  endtask

  // Mode 0 master: data set while SCK low, sampled on rising SCK.
  task automatic b_word(input logic [WB-1:0] w);
    for (int i = 0; i < WB; i++) begin
      mosi_b = w[WB-1-i];
      half();
      sck_b = 1'b1;
      half();
      sck_b = 1'b0;
    end
  endtask

  typedef struct {
    logic [WB-1:0] word;
    int            nbits;
    int            exp_dv;
    int            exp_err;
    logic [WB-1:0] exp_word;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [WB-1:0] echo, echo2;
    logic          m;
    int            exp_cnt;
    int            e0;
    int            lat;
    bit            found;
    logic [WB-1:0] w;

    vecs[0] = '{word: 24'hAA5500, nbits: 24, exp_dv: 1, exp_err: 0, exp_word: 24'hAA5500};
    vecs[1] = '{word: 24'h55AA00, nbits: 24, exp_dv: 1, exp_err: 0, exp_word: 24'h55AA00};
    vecs[2] = '{word: 24'h123456, nbits: 24, exp_dv: 1, exp_err: 0, exp_word: 24'h123456};
    vecs[3] = '{word: 24'hFEDCBA, nbits: 24, exp_dv: 1, exp_err: 0, exp_word: 24'hFEDCBA};
    vecs[4] = '{word: 24'h3C3C3C, nbits: 10, exp_dv: 0, exp_err: 1, exp_word: 24'hFEDCBA};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(ifa.o_SPI_MISO), 32'd0);
    check("rst_word", 32'(ifa.o_RX_Word), 32'd0);
    check("rst_dv", 32'(ifa.o_RX_DV), 32'd0);
    check("rst_err", 32'(ifa.o_Frame_Err), 32'd0);
    check("rst_cnt", 32'(ifa.o_Word_Count), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    exp_cnt = 0;

    // Table: one CS frame per record
    for (int v = 0; v < 5; v++) begin
      qa.delete();
      e0 = erra;
      a_cs_low();
      a_word(vecs[v].word, vecs[v].nbits, echo);
      a_cs_high();
      exp_cnt = (exp_cnt + vecs[v].exp_dv) % 256;
      check($sformatf("vec%0d_dv_n", v), 32'(qa.size()), 32'(vecs[v].exp_dv));
      if (vecs[v].exp_dv > 0)
        check($sformatf("vec%0d_dv_word", v), (qa.size() > 0) ? 32'(qa[0]) : 32'hDEADBEEF,
              32'(vecs[v].exp_word));
      check($sformatf("vec%0d_err_n", v), 32'(erra - e0), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d_rx_word", v), 32'(ifa.o_RX_Word), 32'(vecs[v].exp_word));
      check($sformatf("vec%0d_cnt", v), 32'(ifa.o_Word_Count), 32'(exp_cnt));
    end

    // Two words in one CS assertion
    qa.delete();
    e0 = erra;
    a_cs_low();
    a_word(24'h123456, 24, echo);
    a_word(24'hFEDCBA, 24, echo2);
    a_cs_high();
    exp_cnt = (exp_cnt + 2) % 256;
    check("b2b_dv_n", 32'(qa.size()), 32'd2);
    check("b2b_word0", (qa.size() > 0) ? 32'(qa[0]) : 32'hDEADBEEF, 32'h123456);
    check("b2b_word1", (qa.size() > 1) ? 32'(qa[1]) : 32'hDEADBEEF, 32'hFEDCBA);
    check("b2b_cnt", 32'(ifa.o_Word_Count), 32'(exp_cnt));
    check("b2b_err_n", 32'(erra - e0), 32'd0);
`ifdef SPI_SLAVE_ECHO_EN
    check("echo_word2", 32'(echo2), 32'h123456);
`endif

    // DV latency from the raw SCK sample edge of the last bit
    qa.delete();
    w = 24'h0F1E2D;
    a_cs_low();
    a_word(w, 23, echo);
    sck_a  = 1'b0;
    mosi_a = w[0];
    half();
    sck_a = 1'b1;
    lat   = 0;
    found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(posedge clk);
      #1;
      if (ifa.o_RX_DV) begin
        lat   = k;
        found = 1'b1;
      end
    end
    half();
    a_cs_high();
    exp_cnt = (exp_cnt + 1) % 256;
    check("dv_latency", 32'(lat), 32'd4);
    check("lat_word", (qa.size() > 0) ? 32'(qa[0]) : 32'hDEADBEEF, 32'h0F1E2D);

    // Last sample edge and CS rise in the same instant
    qa.delete();
    e0 = erra;
    w  = 24'hC3A591;
    a_cs_low();
    a_word(w, 23, echo);
    sck_a  = 1'b0;
    mosi_a = w[0];
    half();
    sck_a = 1'b1;
    cs_a  = 1'b1;
    repeat (3) half();
    exp_cnt = (exp_cnt + 1) % 256;
    check("simul_dv_n", 32'(qa.size()), 32'd1);
    check("simul_word", (qa.size() > 0) ? 32'(qa[0]) : 32'hDEADBEEF, 32'hC3A591);
    check("simul_err_n", 32'(erra - e0), 32'd0);
    check("simul_cnt", 32'(ifa.o_Word_Count), 32'(exp_cnt));

    // Reset mid-frame, released while CS_n still low
    qa.delete();
    e0 = erra;
    a_cs_low();
    a_word(24'hFFFFFF, 10, echo);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 0;
    a_word(24'hFFFFFF, 14, echo);
    a_word(24'h654321, 24, echo);
    check("rstmid_dv_n", 32'(qa.size()), 32'd0);
    check("rstmid_err_n", 32'(erra - e0), 32'd0);
    check("rstmid_word", 32'(ifa.o_RX_Word), 32'd0);
    a_cs_high();
    check("rstmid_err_after_cs", 32'(erra - e0), 32'd0);
    a_cs_low();
    a_word(24'hAA5500, 24, echo);
    a_cs_high();
    exp_cnt = (exp_cnt + 1) % 256;
    check("rstmid_next_n", 32'(qa.size()), 32'd1);
    check("rstmid_next_word", (qa.size() > 0) ? 32'(qa[0]) : 32'hDEADBEEF, 32'hAA5500);
    check("rstmid_cnt", 32'(ifa.o_Word_Count), 32'(exp_cnt));

    // Mode 0 capture
    cs_b = 1'b0;
    half();
    b_word(24'hA5A5A5);
    half();
    cs_b = 1'b1;
    half();
    half();
    check("m0_dv_n", 32'(qb.size()), 32'd1);
    check("m0_word", (qb.size() > 0) ? 32'(qb[0]) : 32'hDEADBEEF, 32'hA5A5A5);
    check("m0_err_n", 32'(errb), 32'd0);

    // 256 words: the 8-bit count returns to its start value
    qa.delete();
    e0 = erra;
    a_cs_low();
    for (int i = 0; i < 256; i++) a_word({8'(i), 16'hC35A}, 24, echo);
    a_cs_high();
    check("wrap_dv_n", 32'(qa.size()), 32'd256);
    check("wrap_cnt", 32'(ifa.o_Word_Count), 32'(exp_cnt));
    check("wrap_last", (qa.size() > 255) ? 32'(qa[255]) : 32'hDEADBEEF, 32'hFFC35A);
    check("wrap_err_n", 32'(erra - e0), 32'd0);

    check("dv_err_overlap", 32'(both_hi), 32'd0);
`ifndef SPI_SLAVE_ECHO_EN
    check("miso_tied_low", 32'(miso_hi), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
